// File: rtl/bc_turn_controller.sv
// Turn sequencer for two-player Bulls & Cows: secret/guess capture, scorer handshake, LED result, win/draw.
// Optional macro BC_SHOW_TIMEOUT_EN: SHOW also exits after RESULT_HOLD idle cycles.
module bc_turn_controller #(
    parameter int MAX_ROUNDS  = 15,
    parameter int DIGIT_MAX   = 9,
    parameter int RESULT_HOLD = 100_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        confirma,
    input  logic [15:0] SW,
    output logic        score_req,
    input  logic        score_ack,
    output logic [15:0] score_guess,
    output logic [15:0] score_secret,
    input  logic [2:0]  score_bulls,
    input  logic [2:0]  score_cows,
    output logic [2:0]  state,
    output logic        player,
    output logic [3:0]  round,
    output logic [1:0]  winner,
    output logic        err,
    output logic [15:0] LED
);

    typedef enum logic [2:0] {
        ST_SECRET1 = 3'd0,
        ST_SECRET2 = 3'd1,
        ST_GUESS   = 3'd2,
        ST_SCORE   = 3'd3,
        ST_SHOW    = 3'd4,
        ST_WIN     = 3'd5,
        ST_DRAW    = 3'd6
    } state_t;

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    function automatic logic entry_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (int'(v[4*i +: 4]) > DIGIT_MAX) ok = 1'b0;
            else ok = ok;
            for (int j = i + 1; j < 4; j++) begin
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
                else ok = ok;
            end
        end
        return ok;
    endfunction

    // Saturating 4-lamp thermometer; values above 4 light all four lamps.
    function automatic logic [3:0] therm4(input logic [2:0] v);
        return {v >= 3'd4, v >= 3'd3, v >= 3'd2, v >= 3'd1};
    endfunction

    state_t      state_r, state_s;
    logic        sync1_r, sync2_r, sync3_r, press_s, timeout_s;
    logic        player_r, player_s, err_r, err_s, req_r, req_s;
    logic [3:0]  round_r, round_s, round_inc_s;
    logic [1:0]  winner_r, winner_s;
    logic [15:0] secret1_r, secret1_s, secret2_r, secret2_s;
    logic [15:0] guess_r, guess_s, opp_r, opp_s, led_r, led_s;
    logic [2:0]  bulls_r, bulls_s, cows_r, cows_s;

    assign press_s = sync2_r & ~sync3_r;

`ifdef BC_SHOW_TIMEOUT_EN
    localparam logic [31:0] HOLD_LAST = 32'(RESULT_HOLD - 1);
    logic [31:0] hold_r;

    // SHOW dwell counter; sits at zero outside SHOW so it is clear on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  hold_r <= 32'd0;
        else if (state_r != ST_SHOW) hold_r <= 32'd0;
        else                         hold_r <= hold_r + 32'd1;
    end

    assign timeout_s = (state_r == ST_SHOW) && (hold_r == HOLD_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Confirm button synchronizer and edge-detect history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= confirma;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Next-state and next-output computation for the game sequencer.
    always_comb begin
        state_s     = state_r;
        player_s    = player_r;
        round_s     = round_r;
        winner_s    = winner_r;
        err_s       = err_r;
        secret1_s   = secret1_r;
        secret2_s   = secret2_r;
        guess_s     = guess_r;
        opp_s       = opp_r;
        bulls_s     = bulls_r;
        cows_s      = cows_r;
        round_inc_s = player_r ? (round_r + 4'd1) : round_r;
        case (state_r)
            ST_SECRET1, ST_SECRET2, ST_GUESS: begin
                if (press_s) begin
                    if (entry_valid(SW)) begin
                        err_s = 1'b0;
                        if (state_r == ST_SECRET1) begin
                            secret1_s = SW;
                            state_s   = ST_SECRET2;
                        end else if (state_r == ST_SECRET2) begin
                            secret2_s = SW;
                            player_s  = 1'b0;
                            state_s   = ST_GUESS;
                        end else begin
                            guess_s = SW;
                            opp_s   = player_r ? secret1_r : secret2_r;
                            state_s = ST_SCORE;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_SCORE: begin
                if (score_ack) begin
                    bulls_s = score_bulls;
                    cows_s  = score_cows;
                    state_s = ST_SHOW;
                end else begin
                    state_s = ST_SCORE;
                end
            end
            ST_SHOW: begin
                if (press_s || timeout_s) begin
                    if (bulls_r == 3'd4) begin
                        winner_s = player_r ? 2'd2 : 2'd1;
                        state_s  = ST_WIN;
                    end else begin
                        round_s = round_inc_s;
                        if (round_inc_s == MAX_R) begin
                            state_s = ST_DRAW;
                        end else begin
                            player_s = ~player_r;
                            state_s  = ST_GUESS;
                        end
                    end
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_WIN, ST_DRAW: begin
                if (press_s) begin
                    secret1_s = 16'h0000;
                    secret2_s = 16'h0000;
                    round_s   = 4'd0;
                    winner_s  = 2'd0;
                    player_s  = 1'b0;
                    err_s     = 1'b0;
                    state_s   = ST_SECRET1;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_SECRET1;
        endcase

        req_s = (state_s == ST_SCORE);
        case (state_s)
            ST_SHOW: led_s = {player_s, 7'd0, therm4(cows_s), therm4(bulls_s)};
            ST_WIN:  led_s = 16'hFFFF;
            ST_DRAW: led_s = 16'hAAAA;
            default: led_s = {player_s, 15'd0};
        endcase
    end

    // Game state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_SECRET1;
            player_r  <= 1'b0;
            round_r   <= 4'd0;
            winner_r  <= 2'd0;
            err_r     <= 1'b0;
            req_r     <= 1'b0;
            secret1_r <= 16'h0000;
            secret2_r <= 16'h0000;
            guess_r   <= 16'h0000;
            opp_r     <= 16'h0000;
            bulls_r   <= 3'd0;
            cows_r    <= 3'd0;
            led_r     <= 16'h0000;
        end else begin
            state_r   <= state_s;
            player_r  <= player_s;
            round_r   <= round_s;
            winner_r  <= winner_s;
            err_r     <= err_s;
            req_r     <= req_s;
            secret1_r <= secret1_s;
            secret2_r <= secret2_s;
            guess_r   <= guess_s;
            opp_r     <= opp_s;
            bulls_r   <= bulls_s;
            cows_r    <= cows_s;
            led_r     <= led_s;
        end
    end

    assign state        = state_r;
    assign player       = player_r;
    assign round        = round_r;
    assign winner       = winner_r;
    assign err          = err_r;
    assign score_req    = req_r;
    assign score_guess  = guess_r;
    assign score_secret = opp_r;
    assign LED          = led_r;

endmodule

// File: tb/tb_bc_turn_controller.sv
// Randomized bench for bc_turn_controller against a game-level reference model.
module tb_bc_turn_controller;

    localparam int MR = 3;

    logic        clock = 1'b0;
    logic        reset, confirma, score_ack;
    logic [15:0] SW;
    logic [2:0]  score_bulls, score_cows;
    logic        score_req, player, err;
    logic [15:0] score_guess, score_secret, LED;
    logic [2:0]  state;
    logic [3:0]  round;
    logic [1:0]  winner;

    bc_turn_controller #(.MAX_ROUNDS(MR), .DIGIT_MAX(9), .RESULT_HOLD(10)) dut (
        .clock(clock), .reset(reset), .confirma(confirma), .SW(SW),
        .score_req(score_req), .score_ack(score_ack), .score_guess(score_guess),
        .score_secret(score_secret), .score_bulls(score_bulls), .score_cows(score_cows),
        .state(state), .player(player), .round(round), .winner(winner),
        .err(err), .LED(LED)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: game phase 0..6 as in the state encoding of the outputs.
    int          m_state, m_player, m_round, m_winner, m_bulls, m_cows;
    bit          m_err, m_req;
    logic [15:0] m_sec1, m_sec2, m_guess, m_opp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [15:0] v);
        int d[4];
        for (int i = 0; i < 4; i++) d[i] = int'(v[4*i +: 4]);
        for (int i = 0; i < 4; i++) if (d[i] > 9) return 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++) if (d[i] == d[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] rand_valid();
        int p[10];
        int j, t;
        for (int i = 0; i < 10; i++) p[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        return {4'(p[0]), 4'(p[1]), 4'(p[2]), 4'(p[3])};
    endfunction

    task automatic score_of(input logic [15:0] g, input logic [15:0] s, output int b, output int c);
        b = 0; c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (g[4*i +: 4] == s[4*j +: 4]) begin
                    if (i == j) b++;
                    else c++;
                end
    endtask

    function automatic logic [15:0] exp_led();
        logic [15:0] l;
        l = 16'h0000;
        if (m_state == 5) l = 16'hFFFF;
        else if (m_state == 6) l = 16'hAAAA;
        else begin
            l[15] = (m_player == 1);
            if (m_state == 4)
                for (int i = 0; i < 4; i++) begin
                    l[i]     = (m_bulls > i);
                    l[4 + i] = (m_cows > i);
                end
        end
        return l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_player = 0; m_round = 0; m_winner = 0; m_bulls = 0; m_cows = 0;
        m_err = 1'b0; m_req = 1'b0;
        m_sec1 = 16'h0; m_sec2 = 16'h0; m_guess = 16'h0; m_opp = 16'h0;
    endtask

    task automatic model_press(input logic [15:0] v);
        if (m_state <= 2) begin
            if (legal(v)) begin
                m_err = 1'b0;
                if (m_state == 0) begin m_sec1 = v; m_state = 1; end
                else if (m_state == 1) begin m_sec2 = v; m_player = 0; m_state = 2; end
                else begin
                    m_guess = v;
                    m_opp   = (m_player == 0) ? m_sec2 : m_sec1;
                    m_state = 3;
                    m_req   = 1'b1;
                end
            end else m_err = 1'b1;
        end else if (m_state == 4) begin
            if (m_bulls == 4) begin
                m_winner = m_player + 1;
                m_state  = 5;
            end else begin
                if (m_player == 1) m_round++;
                if (m_round == MR) m_state = 6;
                else begin m_player = 1 - m_player; m_state = 2; end
            end
        end else if (m_state >= 5) begin
            m_sec1 = 16'h0; m_sec2 = 16'h0;
            m_round = 0; m_winner = 0; m_player = 0; m_err = 1'b0; m_state = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  32'(state),        32'(m_state));
        check({tag, ".player"}, 32'(player),       32'(m_player));
        check({tag, ".round"},  32'(round),        32'(m_round));
        check({tag, ".winner"}, 32'(winner),       32'(m_winner));
        check({tag, ".err"},    32'(err),          32'(m_err));
        check({tag, ".req"},    32'(score_req),    32'(m_req));
        check({tag, ".guess"},  32'(score_guess),  32'(m_guess));
        check({tag, ".secret"}, 32'(score_secret), 32'(m_opp));
        check({tag, ".led"},    32'(LED),          32'(exp_led()));
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        SW = v;
        confirma = 1'b1;
        repeat (3) @(negedge clock);
        confirma = 1'b0;
        repeat (3) @(negedge clock);
        model_press(v);
        check_all("press");
    endtask

    task automatic ack(input int b, input int c, input int dly);
        repeat (dly) @(negedge clock);
        check("req_hold", 32'(score_req), 32'(m_req));
        score_bulls = 3'(b);
        score_cows  = 3'(c);
        score_ack   = 1'b1;
        @(negedge clock);
        score_ack = 1'b0;
        if (m_state == 3) begin
            m_state = 4; m_bulls = b; m_cows = c; m_req = 1'b0;
        end
        check_all("ack");
    endtask

    int          b, c, r;
    logic [15:0] g;

    initial begin
        reset = 1'b0; confirma = 1'b0; score_ack = 1'b0; SW = 16'h0;
        score_bulls = 3'd0; score_cows = 3'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("reset");
        reset = 1'b1;
        @(negedge clock);

        press(16'h1123);
        check("tp_dup_err", 32'(err), 32'd1);
        // Press latency: FSM acts on the second edge after confirma is first sampled.
        SW = 16'h1234;
        confirma = 1'b1;
        repeat (2) @(negedge clock);
        check("tp_latency_early", 32'(state), 32'd0);
        @(negedge clock);
        check("tp_latency_act", 32'(state), 32'd1);
        confirma = 1'b0;
        repeat (3) @(negedge clock);
        model_press(16'h1234);
        check_all("tp_1234");
        press(16'h12A4);
        check("tp_range_err", 32'(err), 32'd1);
        press(16'h5678);
        press(16'h5687);
        check("tp_secret", 32'(score_secret), 32'h5678);
        ack(2, 2, 2);
        check("tp_led", 32'(LED), 32'h0033);
        press(16'h0);
        check("tp_player", 32'(player), 32'd1);
        press(16'h1234);
        ack(4, 0, 0);
        press(16'h0);
        check("tp_win_led", 32'(LED), 32'hFFFF);
        press(16'h0);

        for (int it = 0; it < 700; it++) begin
            r = int'($urandom_range(9, 0));
            case (m_state)
                0, 1: begin
                    if (r < 3) press(16'($urandom));
                    else if (r < 5) ack(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 0);
                    else press(rand_valid());
                end
                2: begin
                    if (r < 2) press(16'($urandom));
                    else if (r == 2) press((m_player == 0) ? m_sec2 : m_sec1);
                    else press(rand_valid());
                end
                3: begin
                    if (r < 3) press(16'($urandom));
                    score_of(m_guess, m_opp, b, c);
                    if (r > 6) c = int'($urandom_range(7, 0));
                    ack(b, c, int'($urandom_range(3, 0)));
                end
                default: press(16'($urandom));
            endcase
        end

        // Reset while a score request is outstanding.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        press(16'h1234);
        press(16'h5678);
        press(16'h5687);
        #1;
        reset = 1'b0;
        #1;
        check("rst_req_async", 32'(score_req), 32'd0);
        check("rst_state_async", 32'(state), 32'd0);
        model_reset();
        score_bulls = 3'd4;
        score_ack = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        score_ack = 1'b0;
        @(negedge clock);
        check_all("late_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
